// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling from a
// clock-count baud timer, valid/read output handshake, framing and overrun flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             rx_s1_q;
  logic             rx_sync_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovr_q;

  logic bit_end;
  logic half_end;
  logic read_ack;
  logic stop_good;

  assign bit_end   = (cnt_q == BIT_END);
  assign half_end  = (cnt_q == HALF_END);
  assign read_ack  = valid_q & rx_read;
  assign stop_good = (state_q == S_STOP) & bit_end & rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_s1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_sync_q <= rx_s1_q;
      ferr_q    <= 1'b0;
      cnt_q     <= cnt_q + 1'b1;

      // A new byte wins over a same-cycle read; overrun only when the old byte was never read.
      if (stop_good) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        if (valid_q && !rx_read) begin
          ovr_q <= 1'b1;
        end else if (read_ack) begin
          ovr_q <= 1'b0;
        end
      end else if (read_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_sync_q) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (half_end) begin
            cnt_q   <= '0;
            state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, with an event-scheduled model of the
// expected outputs compared every cycle plus literal spot checks.
module tb_uart_rx;

  localparam int unsigned CPB      = 16;
  localparam int          T0_OFF   = 3;
  localparam int          STOP_OFF = T0_OFF + CPB / 2 + 9 * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       rx      = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_read   (rx_read),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum int {EV_BUSY_ON, EV_BUSY_OFF, EV_GOOD, EV_BAD} ev_kind_e;
  typedef struct {
    int         at;
    ev_kind_e   kind;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_busy  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input ev_kind_e k, input logic [7:0] b);
    ev_t e;
    e.at = at;
    e.kind = k;
    e.b = b;
    evq.push_back(e);
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_busy  = 1'b0;
    evq.delete();
  endtask

  // Model update for one clock edge, given the rx_read value sampled there.
  task automatic model_edge(input logic r);
    logic       good;
    logic       rd;
    logic [7:0] gb;
    good = 1'b0;
    gb   = '0;
    rd   = m_valid && r;
    for (int i = 0; i < evq.size(); ) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          EV_BUSY_ON:  m_busy = 1'b1;
          EV_BUSY_OFF: m_busy = 1'b0;
          EV_GOOD: begin
            good   = 1'b1;
            gb     = evq[i].b;
            m_busy = 1'b0;
          end
          default:     m_ferr = 1'b1;
        endcase
        evq.delete(i);
      end else begin
        i++;
      end
    end
    if (good) begin
      if (m_valid && !r) m_ovr = 1'b1;
      else if (rd)       m_ovr = 1'b0;
      m_data  = gb;
      m_valid = 1'b1;
    end else if (rd) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    logic r;
    forever begin
      @(posedge clk);
      cyc++;
      r = rx_read;
      m_ferr = 1'b0;
      if (rst_n) model_edge(r);
      #1;
      check("rx_valid",  rx_valid,  m_valid);
      check("rx_data",   rx_data,   m_data);
      check("frame_err", frame_err, m_ferr);
      check("overrun",   overrun,   m_ovr);
      check("busy",      busy,      m_busy);
    end
  end

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_read_at(input int edge_n);
    do @(negedge clk); while (cyc < edge_n - 1);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  // Called at a negedge; holds each bit for CPB clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    int e0;
    e0 = cyc;
    push(e0 + T0_OFF, EV_BUSY_ON, 8'h00);
    if (stop) push(e0 + STOP_OFF, EV_GOOD, b);
    else      push(e0 + STOP_OFF, EV_BAD, 8'h00);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic receive: byte visible 155 edges after the edge preceding rx fall.
    e0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_edge(e0 + 154);
        check("basic_valid_early", rx_valid, 1'b0);
        wait_edge(e0 + 155);
        check("basic_data", rx_data, 8'hA5);
        check("basic_valid", rx_valid, 1'b1);
        pulse_read_at(e0 + 158);
        wait_edge(e0 + 158);
        check("basic_read_clears", rx_valid, 1'b0);
      end
    join

    // Glitch rejection: 4-clock low pulse.
    @(negedge clk);
    e0 = cyc;
    push(e0 + T0_OFF, EV_BUSY_ON, 8'h00);
    push(e0 + T0_OFF + CPB / 2, EV_BUSY_OFF, 8'h00);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    wait_edge(e0 + 5);
    check("glitch_busy", busy, 1'b1);
    wait_edge(e0 + 12);
    check("glitch_idle", busy, 1'b0);
    check("glitch_no_valid", rx_valid, 1'b0);
    repeat (20) @(negedge clk);

    // Framing error, then a held-low line, then a good byte.
    e0 = cyc;
    fork
      send_frame(8'h3C, 1'b0);
      begin
        wait_edge(e0 + 155);
        check("ferr_pulse", frame_err, 1'b1);
        check("ferr_valid", rx_valid, 1'b0);
        wait_edge(e0 + 156);
        check("ferr_one_cycle", frame_err, 1'b0);
      end
    join
    repeat (40) @(negedge clk);
    rx = 1'b1;
    push(e0 + 203, EV_BUSY_OFF, 8'h00);
    wait_edge(e0 + 202);
    check("break_busy", busy, 1'b1);
    wait_edge(e0 + 203);
    check("break_release", busy, 1'b0);
    check("break_no_valid", rx_valid, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    check("after_break_data", rx_data, 8'h5A);
    check("after_break_valid", rx_valid, 1'b1);
    pulse_read_at(cyc + 2);

    // Overrun: two frames, no read.
    repeat (5) @(negedge clk);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    pulse_read_at(cyc + 2);
    check("ovr_read_valid", rx_valid, 1'b0);
    check("ovr_read_flag", overrun, 1'b0);

    // Read coincides with the second stop sample: new byte wins, no overrun.
    repeat (5) @(negedge clk);
    e0 = cyc;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      pulse_read_at(e0 + CPB * 10 + STOP_OFF);
    join
    check("same_cycle_data", rx_data, 8'h22);
    check("same_cycle_valid", rx_valid, 1'b1);
    check("same_cycle_ovr", overrun, 1'b0);
    pulse_read_at(cyc + 2);

    // Reset during data bit 3 of 0xFF.
    repeat (5) @(negedge clk);
    e0 = cyc;
    push(e0 + T0_OFF, EV_BUSY_ON, 8'h00);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    e0 = cyc;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        wait_edge(e0 + 155);
        check("post_rst_first_data", rx_data, 8'h00);
        check("post_rst_first_valid", rx_valid, 1'b1);
        pulse_read_at(e0 + 157);
      end
    join
    check("post_rst_second_data", rx_data, 8'hFF);
    check("post_rst_second_valid", rx_valid, 1'b1);
    check("post_rst_second_ovr", overrun, 1'b0);

    repeat (5) @(negedge clk);
    summary();
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board UART link: the receive-side counterpart of the push-button-triggered transmit path. It brings the asynchronous `rx` line into the `clk` domain and detects start bits. Each bit is sampled at mid-bit using a clock-count baud timer. Completed 8N1 bytes are held in an output register with a valid/read handshake, and framing errors and overruns are flagged.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); legal range 4 to 2^20 − 1.
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset. Single clock domain.
- `rx`, input, 1: serial line; idle high; asynchronous to `clk`.
- `rx_read`, input, 1: consumer acknowledges `rx_data`; sampled only while `rx_valid` = 1.
- `rx_data`, output, 8: last good byte, LSB received first.
- `rx_valid`, output, 1: `rx_data` holds an unread byte.
- `frame_err`, output, 1: one-cycle pulse; stop bit sampled low.
- `overrun`, output, 1: sticky; set when a good byte arrives while `rx_valid` = 1. Cleared by `rx_read`.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Synchronizer: two flops, `rx` → `rx_s1` → `rx_sync`. Both reset to 1. All decisions use `rx_sync` only.
- Baud counter: width $clog2(CLKS_PER_BIT), counts up, cleared on every state entry and every bit sample. Bit index is 3 bits.
- States:
  - IDLE → START when `rx_sync` = 0.
  - START: when the counter reaches CLKS_PER_BIT/2 − 1 (integer division), sample `rx_sync`. If it is 1, this is a false start: return to IDLE with no flags. If it is 0, go to DATA.
  - DATA: every CLKS_PER_BIT cycles, shift `rx_sync` into the MSB of the shift register (right shift, so the LSB arrives first). After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If the sample is 1, load `rx_data` from the shift register, set `rx_valid`, and go to IDLE. If the sample is 0, pulse `frame_err`, leave `rx_data`/`rx_valid` unchanged, and go to BREAK.
  - BREAK: wait for `rx_sync` = 1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Return to IDLE happens at mid-stop-bit, giving half a bit of resync margin for back-to-back frames.
- Handshake:
  - `rx_valid` falls on the edge after `rx_read` = 1 is sampled.
  - If a good stop bit and `rx_read` occur in the same cycle, the new byte wins: `rx_data` is updated, `rx_valid` stays 1, and `overrun` is not set.
  - If a good stop bit occurs while `rx_valid` = 1 and `rx_read` = 0, `rx_data` is overwritten with the new byte and `overrun` is set.
- Reset, asynchronous:
  - State = IDLE, counters = 0, shift register = 0.
  - `rx_data` = 0x00; `rx_valid`, `frame_err`, `overrun`, `busy` = 0.
  - A reset mid-frame abandons the frame; no partial byte is ever presented.

## Timing
- Let t0 be the edge where IDLE sees `rx_sync` = 0. `rx_sync` lags `rx` by 2 edges.
- Start sample at t0 + H, where H = CLKS_PER_BIT/2.
- Data bit n (0..7) sampled at t0 + H + (n+1)·CLKS_PER_BIT.
- Stop bit sampled at S = t0 + H + 9·CLKS_PER_BIT.
- At S, the following take effect on that edge and are visible in cycle S+1:
  - `rx_valid`/`rx_data` update, or the `frame_err` pulse.
  - `busy` falls.
- `busy` rises in cycle t0+1.
- `rx_read` → `rx_valid` low: 1 cycle.
- Throughput: one byte per 10·CLKS_PER_BIT cycles, sustained without loss if every byte is read before the next stop sample.

## Test plan
Bit period 16 clocks, `CLKS_PER_BIT` = 16, for all cases.
- **Basic receive:** drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop). Expect `rx_data` = 0xA5 and `rx_valid` = 1 exactly 2 + 8 + 144 + 1 = 155 cycles after `rx` falls. Pulse `rx_read`; `rx_valid` = 0 one cycle later.
- **Glitch rejection:** pull `rx` low for 4 clocks, then high. Expect `busy` to pulse, then return to IDLE. No `rx_valid`, no `frame_err`.
- **Framing error:** send 0x3C with the stop bit low, then hold `rx` low 40 clocks, then release. Expect one `frame_err` pulse, `rx_valid` unchanged, and no further frames until the line goes high. Then 0x5A is received correctly.
- **Overrun:** send 0x11 then 0x22 back to back, no read. Expect `rx_data` = 0x22, `rx_valid` = 1, `overrun` = 1. `rx_read` clears both flags. Repeat with `rx_read` asserted in the same cycle as 0x22's stop sample: expect `overrun` = 0 and `rx_valid` = 1.
- **Reset mid-frame:** assert `rst_n` = 0 during data bit 3 of 0xFF. Expect all outputs at reset values immediately. After release, 0x00 followed by 0xFF back to back are both received intact.
